// File: rtl/data_c_beat_pack.sv
// Serial-to-parallel packer: gathers NUM beats of DSIZE into one registered valid/ready word.
// Optional partial-word flush and lane count: define DATA_C_BEAT_PACK_FLUSH_EN.
module data_c_beat_pack #(
    parameter int unsigned NUM   = 4,
    parameter int unsigned DSIZE = 32
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DSIZE-1:0]           in_data,
    output logic                       in_ready,
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
    input  logic                       flush,
    output logic [$clog2(NUM+1)-1:0]   out_cnt,
`endif
    output logic                       out_valid,
    output logic [NUM*DSIZE-1:0]       out_data,
    input  logic                       out_ready
);

    localparam int unsigned CW  = $clog2(NUM);
    localparam int unsigned OCW = $clog2(NUM + 1);
    localparam logic [CW-1:0] CntLast = CW'(NUM - 1);

    logic [CW-1:0]        cnt_q;
    logic [DSIZE-1:0]     lane_q [NUM-1];
    logic [NUM*DSIZE-1:0] out_data_q;
    logic                 out_valid_q;

    logic                 slot_free;
    logic                 cnt_last;
    logic                 accept;
    logic                 complete;
    logic                 flush_fire;
    logic [NUM*DSIZE-1:0] full_word;

    assign slot_free = !out_valid_q || out_ready;
    assign cnt_last  = (cnt_q == CntLast);
    // Only the final beat of a word needs the output slot, so earlier beats keep flowing.
    assign in_ready  = !cnt_last || slot_free;
    assign accept    = in_valid && in_ready;
    assign complete  = accept && cnt_last;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        full_word = '0;
        for (int i = 0; i < int'(NUM) - 1; i++) begin
            full_word[i*DSIZE +: DSIZE] = lane_q[i];
        end
        full_word[(NUM-1)*DSIZE +: DSIZE] = in_data;
    end

`ifdef DATA_C_BEAT_PACK_FLUSH_EN
    logic [NUM*DSIZE-1:0] part_word;
    logic [OCW-1:0]       part_cnt;
    logic [OCW-1:0]       out_cnt_q;

    // A beat accepted alongside the flush lands in lane cnt and is emitted with the rest.
    assign flush_fire = flush && slot_free && !complete && ((cnt_q != '0) || accept);
    assign part_cnt   = OCW'(cnt_q) + OCW'(accept);
    assign out_cnt    = out_cnt_q;

    always_comb begin
        part_word = '0;
        for (int i = 0; i < int'(NUM) - 1; i++) begin
            if (i < int'(cnt_q)) begin
                part_word[i*DSIZE +: DSIZE] = lane_q[i];
            end else if ((i == int'(cnt_q)) && accept) begin
                part_word[i*DSIZE +: DSIZE] = in_data;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_cnt_q <= '0;
        end else if (complete) begin
            out_cnt_q <= OCW'(NUM);
        end else if (flush_fire) begin
            out_cnt_q <= part_cnt;
        end
    end
`else
    assign flush_fire = 1'b0;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (complete || flush_fire) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Lanes are never cleared on completion; the next word's beats overwrite them.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM) - 1; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM) - 1; i++) begin
                if (accept && !cnt_last && (cnt_q == CW'(i))) begin
                    lane_q[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (complete) begin
            out_valid_q <= 1'b1;
            out_data_q  <= full_word;
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
        end else if (flush_fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= part_word;
`endif
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_c_beat_pack.sv
// Directed + random bench for data_c_beat_pack with a packing scoreboard and stall monitor.
module tb_data_c_beat_pack;

    localparam int unsigned NUM   = 4;
    localparam int unsigned DSIZE = 32;
    localparam int unsigned W     = NUM * DSIZE;

    logic             clock = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [DSIZE-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_ready;
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
    logic             flush;
    logic [$clog2(NUM+1)-1:0] out_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rnd_ready = 1'b0;

    logic [W-1:0]     exp_q [$];
    logic [DSIZE-1:0] part  [$];
    int               hs_cyc[$];

    data_c_beat_pack #(.NUM(NUM), .DSIZE(DSIZE)) dut (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
        .flush     (flush),
        .out_cnt   (out_cnt),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_push(input logic [DSIZE-1:0] d);
        logic [W-1:0] w;
        part.push_back(d);
        if (part.size() == NUM) begin
            w = '0;
            for (int i = 0; i < int'(NUM); i++) w[i*DSIZE +: DSIZE] = part[i];
            exp_q.push_back(w);
            part.delete();
        end
    endtask

    task automatic model_flush();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < part.size(); i++) w[i*DSIZE +: DSIZE] = part[i];
        exp_q.push_back(w);
        part.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
    task automatic send_beat(input logic [DSIZE-1:0] d, output int waits);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        waits    = 0;
        acc      = 1'b0;
        while (!acc && waits < 200) begin
            @(negedge clock);
            acc = in_ready;
            waits++;
            @(posedge clock);
            #1;
        end
        check("beat_accepted", W'(acc), W'(1));
        if (acc) model_push(d);
    endtask

    // Scoreboard pop on every output handshake, plus hold-stability while stalled.
    logic [W-1:0] held;
    bit           hold_pend = 1'b0;
    always @(negedge clock) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid_held", W'(out_valid), W'(1));
                check("stall_data_held", out_data, held);
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, '0 - 1);
                end else begin
                    check("word", out_data, exp_q.pop_front());
                end
            end
            hold_pend = out_valid && !out_ready;
            held      = out_data;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int           waits;
        logic [W-1:0] w1;
        logic [W-1:0] w2;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset values
        @(negedge clock);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
        check("rst_out_cnt", W'(out_cnt), W'(0));
`endif
        step();
        rst = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", W'(in_ready), W'(1));
        step();

        // Basic pack, single-cycle out_valid
        send_beat(32'h11, waits);
        send_beat(32'h22, waits);
        send_beat(32'h33, waits);
        send_beat(32'h44, waits);
        in_valid = 1'b0;
        @(negedge clock);
        check("basic_valid", W'(out_valid), W'(1));
        check("basic_data", out_data, 128'h00000044_00000033_00000022_00000011);
`ifdef DATA_C_BEAT_PACK_FLUSH_EN
        check("basic_out_cnt", W'(out_cnt), W'(NUM));
`endif
        step();
        @(negedge clock);
        check("basic_valid_drop", W'(out_valid), W'(0));
        step();

        // Eight beats back-to-back: no stalls, words 4 cycles apart
        hs_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send_beat(DSIZE'(32'hA0 + i), waits);
            check("b2b_one_cycle", W'(waits), W'(1));
        end
        in_valid = 1'b0;
        step();
        step();
        check("b2b_word_count", W'(hs_cyc.size()), W'(2));
        if (hs_cyc.size() == 2) check("b2b_spacing", W'(hs_cyc[1] - hs_cyc[0]), W'(4));

        // Output stalled: seven beats accepted, eighth blocked until out_ready
        out_ready = 1'b0;
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < 7; i++) begin
            send_beat(DSIZE'(32'h100 + i), waits);
            check("stall_fill_one_cycle", W'(waits), W'(1));
            if (i < 4) w1[i*DSIZE +: DSIZE] = DSIZE'(32'h100 + i);
            else       w2[(i-4)*DSIZE +: DSIZE] = DSIZE'(32'h100 + i);
        end
        w2[3*DSIZE +: DSIZE] = 32'h107;
        in_data = 32'h107;
        @(negedge clock);
        check("full_in_ready_low", W'(in_ready), W'(0));
        check("full_out_data", out_data, w1);
        step();
        @(negedge clock);
        check("full_in_ready_low2", W'(in_ready), W'(0));
        step();
        out_ready = 1'b1;
        @(negedge clock);
        check("release_in_ready", W'(in_ready), W'(1));
        step();
        model_push(32'h107);
        in_valid = 1'b0;
        @(negedge clock);
        check("release_word2_valid", W'(out_valid), W'(1));
        check("release_word2_data", out_data, w2);
        step();
        step();

        // Reset mid-word discards partial beats
        send_beat(32'hDEAD0001, waits);
        send_beat(32'hDEAD0002, waits);
        in_valid = 1'b0;
        rst = 1'b1;
        part.delete();
        step();
        rst = 1'b0;
        @(negedge clock);
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_out_valid", W'(out_valid), W'(0));
        step();
        for (int i = 0; i < 4; i++) send_beat(DSIZE'(32'hB0 + i), waits);
        in_valid = 1'b0;
        @(negedge clock);
        check("midrst_word", out_data, 128'h000000B3_000000B2_000000B1_000000B0);
        step();

        // Random valid/ready over 1000 beats
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) step();
            end
            send_beat($urandom, waits);
        end
        in_valid  = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("rand_drained", W'(exp_q.size()), W'(0));
        check("rand_no_partial", W'(part.size()), W'(0));

`ifdef DATA_C_BEAT_PACK_FLUSH_EN
        // Partial flush of three beats, then next word starts at lane 0
        send_beat(32'hA, waits);
        send_beat(32'hB, waits);
        send_beat(32'hC, waits);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        model_flush();
        @(negedge clock);
        check("flush_valid", W'(out_valid), W'(1));
        check("flush_data", out_data, 128'h00000000_0000000C_0000000B_0000000A);
        check("flush_out_cnt", W'(out_cnt), W'(3));
        step();
        for (int i = 0; i < 4; i++) send_beat(DSIZE'(32'hC0 + i), waits);
        in_valid = 1'b0;
        @(negedge clock);
        check("after_flush_word", out_data, 128'h000000C3_000000C2_000000C1_000000C0);
        check("after_flush_cnt", W'(out_cnt), W'(NUM));
        step();
        step();
        check("flush_drained", W'(exp_q.size()), W'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
